// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the stereo-to-mono decimation path.
//   - default sample and FIFO word widths
//   - width of the saturating status counters
//   - FSM state encoding used by stereo_to_mono_decimator
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int DEF_SAMPLE_WIDTH = 24;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int CNT_W            = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SUM   = 2'd1,
        ST_ACCUM = 2'd2,
        ST_PUSH  = 2'd3
    } state_t;

endpackage

// File: rtl/stereo_to_mono_decimator_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   i_clk   : clock
//   i_clr   : synchronous clear, wins over increment
//   i_inc   : increment by one when not already saturated
//   o_count : current count
// -----------------------------------------------------------------------------
module sat_counter
    import audio_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] MAX_CNT = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX_CNT)) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/stereo_to_mono_decimator.sv
// -----------------------------------------------------------------------------
// stereo_to_mono_decimator
// Averages each stereo pair to mono, averages groups of 2^DECIM_LOG2 mono
// samples, and writes the result left-justified into a downstream FIFO.
//
// Ports
//   clk, reset     : clock, synchronous active-high reset
//   enable         : 0 holds Idle and discards any partial group
//   left_sample    : signed left channel, valid with sample_valid
//   right_sample   : signed right channel, valid with sample_valid
//   sample_valid   : one-cycle strobe for a new stereo pair
//   fifo_full      : downstream FIFO cannot take a write (looked at in Push only)
//   fifo_wr_en     : one-cycle write strobe
//   fifo_din       : {result, zero pad}; holds last written word otherwise
//   drop_count     : saturating count of words lost to fifo_full
//   overrun        : sticky, a pair arrived while the FSM was busy
// -----------------------------------------------------------------------------
module stereo_to_mono_decimator
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int DECIM_LOG2   = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic signed [SAMPLE_WIDTH-1:0] left_sample,
    input  logic signed [SAMPLE_WIDTH-1:0] right_sample,
    input  logic                           sample_valid,
    input  logic                           fifo_full,
    output logic                           fifo_wr_en,
    output logic signed [DATA_WIDTH-1:0]   fifo_din,
    output logic [CNT_W-1:0]               drop_count,
    output logic                           overrun
);

    localparam int ACC_W  = SAMPLE_WIDTH + DECIM_LOG2;
    localparam int GCNT_W = DECIM_LOG2 + 1;
    localparam int PAD_W  = DATA_WIDTH - SAMPLE_WIDTH;
    localparam logic [GCNT_W-1:0] GROUP_N  = GCNT_W'(1 << DECIM_LOG2);
    localparam logic [GCNT_W-1:0] GCNT_ONE = GCNT_W'(1);

    if (DATA_WIDTH < SAMPLE_WIDTH) begin : g_bad_width
        $error("DATA_WIDTH must be >= SAMPLE_WIDTH");
    end
    if (DECIM_LOG2 < 0 || DECIM_LOG2 > 4) begin : g_bad_decim
        $error("DECIM_LOG2 must be in 0..4");
    end

    state_t                         r_state;
    logic signed [SAMPLE_WIDTH-1:0] r_left;
    logic signed [SAMPLE_WIDTH-1:0] r_right;
    logic signed [SAMPLE_WIDTH-1:0] r_mono;
    logic signed [ACC_W-1:0]        r_acc;
    logic [GCNT_W-1:0]              r_gcnt;
    logic signed [SAMPLE_WIDTH-1:0] r_result;
    logic                           r_wr_en;
    logic [DATA_WIDTH-1:0]          r_din;
    logic                           r_overrun;

    logic signed [SAMPLE_WIDTH:0]   w_pair_sum;
    logic signed [SAMPLE_WIDTH-1:0] w_mono;
    logic signed [ACC_W-1:0]        w_acc_next;
    logic [GCNT_W-1:0]              w_gcnt_next;
    logic                           w_group_done;
    logic signed [SAMPLE_WIDTH-1:0] w_result;
    logic [DATA_WIDTH-1:0]          w_word;
    logic                           w_drop;

    // One extra bit so L+R never wraps; the halving brings it back in range.
    assign w_pair_sum = {r_left[SAMPLE_WIDTH-1], r_left} + {r_right[SAMPLE_WIDTH-1], r_right};
    assign w_mono     = SAMPLE_WIDTH'(w_pair_sum >>> 1);

    // The accumulator has DECIM_LOG2 bits of headroom, so a full group of
    // extreme samples cannot overflow before the final divide.
    assign w_acc_next   = r_acc + ACC_W'(r_mono);
    assign w_gcnt_next  = r_gcnt + GCNT_ONE;
    assign w_group_done = (w_gcnt_next == GROUP_N);
    assign w_result     = SAMPLE_WIDTH'(w_acc_next >>> DECIM_LOG2);

    // Zero-extend then shift up: left-justifies the result and also covers
    // the PAD_W == 0 case without a zero-width replication.
    assign w_word = DATA_WIDTH'($unsigned(r_result)) << PAD_W;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_left    <= '0;
            r_right   <= '0;
            r_mono    <= '0;
            r_acc     <= '0;
            r_gcnt    <= '0;
            r_result  <= '0;
            r_wr_en   <= 1'b0;
            r_din     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;

            // Pairs arriving while busy are dropped on the floor, but flagged.
            if (sample_valid && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end

            if (!enable) begin
                r_state <= ST_IDLE;
                r_acc   <= '0;
                r_gcnt  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (sample_valid) begin
                            r_left  <= left_sample;
                            r_right <= right_sample;
                            r_state <= ST_SUM;
                        end
                    end
                    ST_SUM: begin
                        r_mono  <= w_mono;
                        r_state <= ST_ACCUM;
                    end
                    ST_ACCUM: begin
                        if (w_group_done) begin
                            r_result <= w_result;
                            r_acc    <= '0;
                            r_gcnt   <= '0;
                            r_state  <= ST_PUSH;
                        end else begin
                            r_acc   <= w_acc_next;
                            r_gcnt  <= w_gcnt_next;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_PUSH: begin
                        if (!fifo_full) begin
                            r_wr_en <= 1'b1;
                            r_din   <= w_word;
                        end
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // A word is lost only when Push actually runs (enabled, not in reset).
    assign w_drop = !reset && enable && (r_state == ST_PUSH) && fifo_full;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_drop_cnt (
        .i_clk   (clk),
        .i_clr   (reset),
        .i_inc   (w_drop),
        .o_count (drop_count)
    );

    assign fifo_wr_en = r_wr_en;
    assign fifo_din   = $signed(r_din);
    assign overrun    = r_overrun;

endmodule
